lsu_ctrl: RTL

Load/store controller sitting directly upstream of the byte-wide data RAM in the LSU. Accepts 8- or 16-bit load/store requests from the core over a valid/ready handshake. Sequences them into one or two single-byte RAM accesses, little-endian, and range-checks against the RAM size. Returns load data or a fault over a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: controller states, RAM size default and op encodings.
// The RAM model and the future LSU top import these as well.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACC_LO,
      ACC_HI,
      CAP,
      RSP
   } state_t;

   localparam int MEM_SIZE_DEF = 32768;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;
   localparam logic W_BYTE   = 1'b0;
   localparam logic W_HALF   = 1'b1;

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store controller: splits 8/16-bit requests into little-endian byte
// accesses on the data RAM, range-checks them and returns data or a fault.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int MEM_SIZE = MEM_SIZE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_wide,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [15:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_d,
   output logic              ram_re,
   output logic              ram_we,
   input  logic [7:0]        ram_q
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_SIZE);

   state_t            state, state_n;
   logic              rst_done;
   logic              r_we, r_wide, r_signed, r_fault;
   logic [ADDR_W-1:0] r_addr, r_addr_hi;
   logic [15:0]       r_wdata, result;
   logic [ADDR_W:0]   end_addr;
   logic              req_flt, accept;

   // last byte touched, one bit wider so 0xFFFF+1 cannot wrap back in range
   assign end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(req_wide);
   assign req_flt   = (end_addr >= LIMIT);
   assign r_addr_hi = r_addr + ADDR_W'(1);

   assign req_ready = (state == IDLE) && rst_done;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RSP);
   assign rsp_rdata = result;
   assign rsp_fault = r_fault;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rst_done <= 1'b0;
      end else begin
         state    <= state_n;
         rst_done <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      ram_a   = '0;
      ram_d   = '0;
      ram_re  = 1'b0;
      ram_we  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_n = req_flt ? RSP : ACC_LO;
         end
         ACC_LO: begin
            ram_a  = r_addr;
            ram_d  = r_wdata[7:0];
            ram_we = (r_we == OP_STORE);
            ram_re = (r_we == OP_LOAD);
            if (r_wide == W_HALF)       state_n = ACC_HI;
            else if (r_we == OP_STORE)  state_n = RSP;
            else                        state_n = CAP;
         end
         ACC_HI: begin
            ram_a   = r_addr_hi;
            ram_d   = r_wdata[15:8];
            ram_we  = (r_we == OP_STORE);
            ram_re  = (r_we == OP_LOAD);
            state_n = (r_we == OP_STORE) ? RSP : CAP;
         end
         CAP: state_n = RSP;
         RSP: if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ram_q always carries the byte strobed in the previous state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we     <= 1'b0;
         r_wide   <= 1'b0;
         r_signed <= 1'b0;
         r_fault  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         result   <= '0;
      end else if (accept) begin
         r_we     <= req_we;
         r_wide   <= req_wide;
         r_signed <= req_signed;
         r_fault  <= req_flt;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
         result   <= '0;
      end else begin
         case (state)
            ACC_HI: if (r_we == OP_LOAD) result[7:0] <= ram_q;
            CAP: begin
               if (r_wide == W_HALF) result[15:8] <= ram_q;
               else result <= {(r_signed ? {8{ram_q[7]}} : 8'h00), ram_q};
            end
            default: ;
         endcase
      end
   end

endmodule
